// File: rtl/core_run_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// core_run_ctrl
//
// Host-facing run controller for a small processor core. The host loads
// instruction words into a 64-word instruction memory, then starts, single
// steps or halts the core. Optional hardware breakpoint on a PC match.
//
// Ports
//   clk          rising-edge clock for all state
//   reset        asynchronous active-low reset
//   host_valid   host command valid
//   host_ready   command accepted when host_valid && host_ready (low in STEP)
//   host_cmd     00 LOAD, 01 RUN, 10 STEP, 11 HALT
//   host_data    instruction word for LOAD
//   imem_we      registered instruction-memory write strobe
//   imem_addr    registered word address of the write
//   imem_wdata   registered write data
//   core_rst_n   active-low core reset, low only in IDLE
//   core_en      core clock-enable (PC / register-file update)
//   pc           current core PC
//   bp_en        breakpoint enable
//   bp_addr      breakpoint PC
//   state        00 IDLE, 01 RUN, 10 STEP, 11 HALTED
//   instr_count  saturating count of cycles with core_en high
//   cmd_err      sticky illegal-command flag, cleared only by reset
// -----------------------------------------------------------------------------
module core_run_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        host_valid,
  output logic        host_ready,
  input  logic [1:0]  host_cmd,
  input  logic [31:0] host_data,
  output logic        imem_we,
  output logic [5:0]  imem_addr,
  output logic [31:0] imem_wdata,
  output logic        core_rst_n,
  output logic        core_en,
  input  logic [31:0] pc,
  input  logic        bp_en,
  input  logic [31:0] bp_addr,
  output logic [1:0]  state,
  output logic [15:0] instr_count,
  output logic        cmd_err
);

  // Controller states; encoding is visible on the state output.
  localparam logic [1:0] StIdle   = 2'b00;
  localparam logic [1:0] StRun    = 2'b01;
  localparam logic [1:0] StStep   = 2'b10;
  localparam logic [1:0] StHalted = 2'b11;

  // Host command encoding.
  localparam logic [1:0] CmdLoad = 2'b00;
  localparam logic [1:0] CmdRun  = 2'b01;
  localparam logic [1:0] CmdStep = 2'b10;
  localparam logic [1:0] CmdHalt = 2'b11;

  localparam logic [15:0] CountMax = 16'hFFFF;

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  logic [1:0]  state_q,      state_d;
  logic [5:0]  load_ptr_q,   load_ptr_d;
  logic        run_first_q,  run_first_d;
  logic [15:0] count_q,      count_d;
  logic        cmd_err_q,    cmd_err_d;
  logic        imem_we_q,    imem_we_d;
  logic [5:0]  imem_addr_q,  imem_addr_d;
  logic [31:0] imem_wdata_q, imem_wdata_d;

  // ---------------------------------------------------------------------------
  // Status decode
  // ---------------------------------------------------------------------------
  logic in_idle;
  logic in_run;
  logic in_step;
  logic in_halted;

  assign in_idle   = (state_q == StIdle);
  assign in_run    = (state_q == StRun);
  assign in_step   = (state_q == StStep);
  assign in_halted = (state_q == StHalted);

  // ---------------------------------------------------------------------------
  // Command handshake decode
  // ---------------------------------------------------------------------------
  logic cmd_accept;
  logic acc_load;
  logic acc_run;
  logic acc_step;
  logic acc_halt;

  // STEP lasts exactly one cycle, so commands are simply held off for it.
  assign host_ready = ~in_step;
  assign cmd_accept = host_valid & host_ready;

  assign acc_load = cmd_accept & (host_cmd == CmdLoad);
  assign acc_run  = cmd_accept & (host_cmd == CmdRun);
  assign acc_step = cmd_accept & (host_cmd == CmdStep);
  assign acc_halt = cmd_accept & (host_cmd == CmdHalt);

  // ---------------------------------------------------------------------------
  // Breakpoint and core enable
  // ---------------------------------------------------------------------------
  logic bp_hit;

  // The first RUN cycle is never a hit so that resuming from a breakpoint
  // halt (pc still equal to bp_addr) executes that instruction.
  assign bp_hit = in_run & ~run_first_q & bp_en & (pc == bp_addr);

  // The enable is purely combinational so a hit stalls the core in the very
  // cycle the matching PC is presented.
  assign core_en = (in_run & ~bp_hit) | in_step;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  logic count_clear;

  always_comb begin
    state_d      = state_q;
    load_ptr_d   = load_ptr_q;
    run_first_d  = 1'b0;
    cmd_err_d    = cmd_err_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    count_clear  = 1'b0;

    case (state_q)
      StIdle, StHalted: begin
        if (acc_load) begin
          imem_we_d    = 1'b1;
          imem_addr_d  = load_ptr_q;
          imem_wdata_d = host_data;
          // 6-bit pointer wraps 63 -> 0 naturally.
          load_ptr_d   = load_ptr_q + 6'd1;
          state_d      = StIdle;
        end else if (acc_run) begin
          state_d     = StRun;
          load_ptr_d  = 6'd0;
          run_first_d = 1'b1;
          count_clear = in_idle;
        end else if (acc_step) begin
          state_d     = StStep;
          count_clear = in_idle;
        end else if (acc_halt) begin
          cmd_err_d = 1'b1;
        end
      end

      StRun: begin
        // A hit coinciding with HALT still halts; core_en is already low.
        if (bp_hit || acc_halt) begin
          state_d = StHalted;
        end
        if (acc_load || acc_run || acc_step) begin
          cmd_err_d = 1'b1;
        end
      end

      StStep: begin
        state_d = StHalted;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Executed-cycle counter: clear wins, otherwise saturating increment.
  always_comb begin
    count_d = count_q;
    if (count_clear) begin
      count_d = 16'd0;
    end else if (core_en && (count_q != CountMax)) begin
      count_d = count_q + 16'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Sequential state
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      load_ptr_q   <= 6'd0;
      run_first_q  <= 1'b0;
      count_q      <= 16'd0;
      cmd_err_q    <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= 6'd0;
      imem_wdata_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      load_ptr_q   <= load_ptr_d;
      run_first_q  <= run_first_d;
      count_q      <= count_d;
      cmd_err_q    <= cmd_err_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign state       = state_q;
  assign core_rst_n  = ~in_idle;
  assign instr_count = count_q;
  assign cmd_err     = cmd_err_q;
  assign imem_we     = imem_we_q;
  assign imem_addr   = imem_addr_q;
  assign imem_wdata  = imem_wdata_q;

  // in_halted is kept for readability of the decode; reference it so it is
  // not flagged as unused.
  logic unused_halted;
  assign unused_halted = in_halted;

endmodule

// File: tb/tb_core_run_ctrl.sv
`timescale 1ns/1ps
module tb_core_run_ctrl;

  localparam logic [1:0] CmdLoad = 2'b00;
  localparam logic [1:0] CmdRun  = 2'b01;
  localparam logic [1:0] CmdStep = 2'b10;
  localparam logic [1:0] CmdHalt = 2'b11;

  localparam logic [1:0] StIdle   = 2'b00;
  localparam logic [1:0] StRun    = 2'b01;
  localparam logic [1:0] StStep   = 2'b10;
  localparam logic [1:0] StHalted = 2'b11;

  logic        clk;
  logic        reset;
  logic        host_valid;
  logic        host_ready;
  logic [1:0]  host_cmd;
  logic [31:0] host_data;
  logic        imem_we;
  logic [5:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        core_rst_n;
  logic        core_en;
  logic [31:0] pc;
  logic        bp_en;
  logic [31:0] bp_addr;
  logic [1:0]  state;
  logic [15:0] instr_count;
  logic        cmd_err;

  core_run_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .host_valid  (host_valid),
    .host_ready  (host_ready),
    .host_cmd    (host_cmd),
    .host_data   (host_data),
    .imem_we     (imem_we),
    .imem_addr   (imem_addr),
    .imem_wdata  (imem_wdata),
    .core_rst_n  (core_rst_n),
    .core_en     (core_en),
    .pc          (pc),
    .bp_en       (bp_en),
    .bp_addr     (bp_addr),
    .state       (state),
    .instr_count (instr_count),
    .cmd_err     (cmd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int en_cycles = 0;

  typedef struct packed {
    logic [5:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_wr(input logic [5:0] a, input logic [31:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] cmd, input logic [31:0] data);
    host_valid = 1'b1;
    host_cmd   = cmd;
    host_data  = data;
    @(posedge clk);
    #1;
    host_valid = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"},      {30'd0, state}, 32'd0);
    chk({tag, "_count"},      {16'd0, instr_count}, 32'd0);
    chk({tag, "_cmd_err"},    {31'd0, cmd_err}, 32'd0);
    chk({tag, "_imem_we"},    {31'd0, imem_we}, 32'd0);
    chk({tag, "_imem_addr"},  {26'd0, imem_addr}, 32'd0);
    chk({tag, "_imem_wdata"}, imem_wdata, 32'd0);
    chk({tag, "_core_en"},    {31'd0, core_en}, 32'd0);
    chk({tag, "_core_rst_n"}, {31'd0, core_rst_n}, 32'd0);
  endtask

  // Monitor: pops the expected write whenever the DUT presents one, and
  // tracks enabled core cycles.
  initial begin
    forever begin
      @(negedge clk);
      if (core_en) en_cycles++;
      if (imem_we) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL imem_unexpected_write: got we=1 addr 0x%0h data 0x%0h required no write",
                   imem_addr, imem_wdata);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("imem_addr", {26'd0, imem_addr}, {26'd0, e.a});
          chk("imem_wdata", imem_wdata, e.d);
        end
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int c0;
    reset      = 1'b0;
    host_valid = 1'b0;
    host_cmd   = CmdLoad;
    host_data  = 32'd0;
    pc         = 32'd0;
    bp_en      = 1'b0;
    bp_addr    = 32'd0;

    #3;
    chk_reset_vals("por");
    #20;
    chk_reset_vals("por_clk");
    chk("por_host_ready", {31'd0, host_ready}, 32'd1);
    reset = 1'b1;

    // Test 1: three loads
    push_wr(6'd0, 32'h2008_0005);
    send(CmdLoad, 32'h2008_0005);
    push_wr(6'd1, 32'h2009_0003);
    send(CmdLoad, 32'h2009_0003);
    push_wr(6'd2, 32'h0109_5020);
    send(CmdLoad, 32'h0109_5020);
    @(negedge clk);
    chk("t1_state", {30'd0, state}, {30'd0, StIdle});
    chk("t1_core_rst_n", {31'd0, core_rst_n}, 32'd0);
    chk("t1_core_en", {31'd0, core_en}, 32'd0);

    // Test 2: RUN then HALT ten cycles later
    send(CmdRun, 32'd0);
    c0 = en_cycles;
    @(negedge clk);
    chk("t2_state_run", {30'd0, state}, {30'd0, StRun});
    chk("t2_core_rst_n", {31'd0, core_rst_n}, 32'd1);
    repeat (10) tick();
    send(CmdHalt, 32'd0);
    chk("t2_en_cycles", en_cycles - c0, 32'd11);
    chk("t2_count", {16'd0, instr_count}, 32'd11);
    chk("t2_state_halted", {30'd0, state}, {30'd0, StHalted});
    chk("t2_core_en_halted", {31'd0, core_en}, 32'd0);

    // Test 3: breakpoint at 0x8 from IDLE
    push_wr(6'd0, 32'h0000_0013);
    send(CmdLoad, 32'h0000_0013);
    @(negedge clk);
    chk("t3_state_idle", {30'd0, state}, {30'd0, StIdle});
    bp_en   = 1'b1;
    bp_addr = 32'h8;
    pc      = 32'h0;
    send(CmdRun, 32'd0);
    c0 = en_cycles;
    @(negedge clk);
    chk("t3_en_pc0", {31'd0, core_en}, 32'd1);
    tick();
    pc = 32'h4;
    tick();
    pc = 32'h8;
    @(negedge clk);
    chk("t3_en_bp_hit", {31'd0, core_en}, 32'd0);
    tick();
    chk("t3_state_halted", {30'd0, state}, {30'd0, StHalted});
    chk("t3_count", {16'd0, instr_count}, 32'd2);
    chk("t3_en_cycles", en_cycles - c0, 32'd2);

    // Test 4: resume with pc still on the breakpoint
    send(CmdRun, 32'd0);
    @(negedge clk);
    chk("t4_en_skip", {31'd0, core_en}, 32'd1);
    chk("t4_state_run", {30'd0, state}, {30'd0, StRun});
    tick();
    pc = 32'hC;
    @(negedge clk);
    chk("t4_no_rehalt", {30'd0, state}, {30'd0, StRun});
    chk("t4_en_second", {31'd0, core_en}, 32'd1);
    send(CmdHalt, 32'd0);
    chk("t4_state_halted", {30'd0, state}, {30'd0, StHalted});
    chk("t4_count", {16'd0, instr_count}, 32'd4);

    // Test 5: STEP from HALTED, breakpoint must be ignored
    pc = 32'h8;
    c0 = en_cycles;
    send(CmdStep, 32'd0);
    @(negedge clk);
    chk("t5_state_step", {30'd0, state}, {30'd0, StStep});
    chk("t5_host_ready", {31'd0, host_ready}, 32'd0);
    chk("t5_en_step", {31'd0, core_en}, 32'd1);
    tick();
    chk("t5_state_halted", {30'd0, state}, {30'd0, StHalted});
    chk("t5_host_ready_after", {31'd0, host_ready}, 32'd1);
    chk("t5_count", {16'd0, instr_count}, 32'd5);
    chk("t5_en_cycles", en_cycles - c0, 32'd1);

    // Test 6: LOAD in RUN is illegal, then reset mid-RUN
    bp_en = 1'b0;
    send(CmdRun, 32'd0);
    send(CmdLoad, 32'hDEAD_BEEF);
    chk("t6_cmd_err", {31'd0, cmd_err}, 32'd1);
    chk("t6_state_run", {30'd0, state}, {30'd0, StRun});
    tick();
    tick();
    #2;
    reset = 1'b0;
    #1;
    chk_reset_vals("t6_async");
    @(posedge clk);
    #2;
    chk_reset_vals("t6_held");
    reset = 1'b1;

    // Load pointer wrap 63 -> 0; first load right after reset release
    for (int i = 0; i < 65; i++) begin
      logic [5:0] a;
      a = i[5:0];
      push_wr(a, 32'hA000_0000 + i);
      send(CmdLoad, 32'hA000_0000 + i);
    end
    @(negedge clk);
    chk("wrap_state_idle", {30'd0, state}, {30'd0, StIdle});

    // HALT in IDLE is illegal
    send(CmdHalt, 32'd0);
    chk("halt_idle_err", {31'd0, cmd_err}, 32'd1);
    chk("halt_idle_state", {30'd0, state}, {30'd0, StIdle});

    // HALT coinciding with a breakpoint hit
    bp_en   = 1'b1;
    bp_addr = 32'h10;
    pc      = 32'h0;
    send(CmdRun, 32'd0);
    tick();
    pc         = 32'h10;
    host_valid = 1'b1;
    host_cmd   = CmdHalt;
    @(negedge clk);
    chk("coinc_en", {31'd0, core_en}, 32'd0);
    @(posedge clk);
    #1;
    host_valid = 1'b0;
    chk("coinc_state", {30'd0, state}, {30'd0, StHalted});
    chk("coinc_count", {16'd0, instr_count}, 32'd1);
    chk("coinc_err_sticky", {31'd0, cmd_err}, 32'd1);

    @(negedge clk);
    chk("pending_writes", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
